// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - application-side frame write port of the 7-segment scan driver
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lz_en;
    logic                    load;
    logic                    pending;

    modport master (output value, output dp, output blank, output lz_en, output load, input pending);
    modport slave  (input value, input dp, input blank, input lz_en, input load, output pending);
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed active-low 7-segment scanner with tear-free frames
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_scan_driver_if.slave     bus,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_start
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] a_value, p_value;
    logic [NUM_DIGITS-1:0]   a_dp, p_dp, a_blank, p_blank;
    logic                    a_lz, p_lz;
    logic                    pending;

    logic                    frame_wrap;
    logic [NUM_DIGITS-1:0]   suppress;
    logic [NUM_DIGITS-1:0]   dark;
    logic                    lz_run;
    logic [3:0]              nibble;
    logic [7:0]              seg_d;
    logic [NUM_DIGITS-1:0]   an_d;

    assign frame_wrap  = (cnt == CNT_LAST) && (idx == IDX_LAST);
    assign bus.pending = pending;

    function automatic logic [6:0] encode(input logic [3:0] n);
        case (n)
            4'h0: encode = 7'h40;
            4'h1: encode = 7'h79;
            4'h2: encode = 7'h24;
            4'h3: encode = 7'h30;
            4'h4: encode = 7'h19;
            4'h5: encode = 7'h12;
            4'h6: encode = 7'h02;
            4'h7: encode = 7'h78;
            4'h8: encode = 7'h00;
            4'h9: encode = 7'h10;
            4'hA: encode = 7'h08;
            4'hB: encode = 7'h03;
            4'hC: encode = 7'h46;
            4'hD: encode = 7'h21;
            4'hE: encode = 7'h06;
            default: encode = 7'h0E;
        endcase
    endfunction

    // Leading-zero suppression walks down from the top digit until a digit with a nonzero nibble or a lit dp
    always_comb begin
        suppress = '0;
        lz_run   = a_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lz_run && (a_value[4*i +: 4] == 4'h0) && !a_dp[i]) begin
                suppress[i] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
    end

    // Next output pattern from the current scan position; guard cycles and dark digits drive nothing
    always_comb begin
        dark   = a_blank | suppress;
        nibble = a_value[4*idx +: 4];
        seg_d  = 8'hFF;
        an_d   = '1;
        if (!((cnt < GUARD_C) || dark[idx])) begin
            seg_d = {~a_dp[idx], encode(nibble)};
            an_d  = ~(NUM_DIGITS'(1) << idx);
        end
    end

    // Prescaler and digit index advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame capture: loads park in P until the frame wrap, except a load on the wrap itself goes straight to A
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_value <= '0;
            a_dp    <= '0;
            a_blank <= '1;
            a_lz    <= 1'b0;
            p_value <= '0;
            p_dp    <= '0;
            p_blank <= '0;
            p_lz    <= 1'b0;
            pending <= 1'b0;
        end else if (bus.load && frame_wrap) begin
            a_value <= bus.value;
            a_dp    <= bus.dp;
            a_blank <= bus.blank;
            a_lz    <= bus.lz_en;
            pending <= 1'b0;
        end else if (bus.load) begin
            p_value <= bus.value;
            p_dp    <= bus.dp;
            p_blank <= bus.blank;
            p_lz    <= bus.lz_en;
            pending <= 1'b1;
        end else if (frame_wrap && pending) begin
            a_value <= p_value;
            a_dp    <= p_dp;
            a_blank <= p_blank;
            a_lz    <= p_lz;
            pending <= 1'b0;
        end
    end

    // Registered pin drive; reset darkens the display without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg         <= 8'hFF;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_d;
            an          <= an_d;
            frame_start <= (cnt == '0) && (idx == '0);
        end
    end
endmodule
